int_seq: RTL and testbench
==========================

// Module: int_seq
// PURPOSE
//   Interrupt and halt sequencer for the 65C02 core. It arbitrates RESET, NMI, IRQ and BRK at
//   each opcode fetch and forces the core into its BRK sequence. It supplies the vector low
//   byte and the B flag value for the stacked P, and suppresses writes during the reset
//   sequence. It implements the WAI and STP halt states. Sits beside the ctl FSM; it drives
//   ctl's opcode override and stalls the core through the halt output.
// PARAMETERS
//   NMI_SYNC  2      synchronizer flops on nmi before edge detect (0..3; 0 = direct)
//   VEC_NMI   8'hFA  vector low byte for NMI
//   VEC_RES   8'hFC  vector low byte for RESET
//   VEC_IRQ   8'hFE  vector low byte for IRQ and BRK
//   OP_WAI    8'hCB  WAI opcode
//   OP_STP    8'hDB  STP opcode
// PORTS
//   clk        in   1  core clock; all state changes on posedge
//   reset      in   1  asynchronous, active-high reset
//   nmi        in   1  NMI pin, active-high, rising-edge sensitive, asynchronous
//   irq        in   1  IRQ pin, active-high, level sensitive
//   I          in   1  interrupt-disable flag from P
//   sync       in   1  opcode fetch cycle from ctl
//   rdy        in   1  external ready; the core advances only when 1
//   DB         in   8  data bus; holds the opcode when sync=1
//   vec_done   in   1  1-cycle pulse from ctl when the vector fetch completes
//   force_brk  out  1  combinational; ctl decodes 8'h00 instead of DB this cycle
//   vec        out  8  registered vector low byte ({FF,vec} is the vector address)
//   B          out  1  registered; 1 = software BRK, 0 = hardware interrupt
//   no_we      out  1  registered; 1 blocks WE (reset pushes become reads)
//   halt       out  1  registered; core stalls as if rdy=0
// BEHAVIOUR
//   Reset values: res_pend=1, nmi_pend=0, state=RUN, vec=VEC_RES, B=0, no_we=1, halt=0.
//     Edge-detect history is cleared to 0.
//   take = sync & rdy & ~halt. Priority on take: res_pend > nmi_pend > (irq & ~I) > DB==8'h00.
//   force_brk = take & (res_pend | nmi_pend | (irq & ~I)). It is 0 for a real BRK opcode.
//   On a take that selects an interrupt or BRK (registered next cycle): state<=SERV, and:
//     RESET -> vec=VEC_RES, B=0, no_we=1
//     NMI   -> vec=VEC_NMI, B=0, no_we=0
//     IRQ   -> vec=VEC_IRQ, B=0, no_we=0
//     BRK   -> vec=VEC_IRQ, B=1, no_we=0
//     The serviced pending bit clears in the same edge.
//   SERV: vec, B and no_we hold. A vec_done pulse returns the FSM to RUN and clears no_we.
//     No takes occur in SERV (sync does not assert).
//   NMI: rising edge of the synchronized nmi sets nmi_pend. Detection latency is NMI_SYNC+1
//     clocks. If a new edge and a take of NMI land in the same cycle, the set wins (stays
//     pending). An edge during SERV/WAIT is held. A constant-high nmi never retriggers.
//   IRQ: sampled only at take. No latching; an irq that drops before the take is lost.
//   WAI: take with DB==OP_WAI and no interrupt selected -> state WAIT, halt=1 next cycle.
//     Exit on nmi_pend or irq (I is ignored for the exit): halt=0 next cycle, state RUN.
//     If irq & I=1, execution resumes at the next opcode without servicing. Otherwise the
//     interrupt is taken at the next sync by normal priority.
//   STP: take with DB==OP_STP and no interrupt selected -> state STOP, halt=1.
//     Only reset exits. nmi and irq are ignored, but NMI edges still set nmi_pend.
//   rdy=0: no state changes except NMI edge capture. take is qualified by rdy.
//   Reset mid-operation (SERV/WAIT/STOP): immediate return to reset values. The first sync
//     after reset release is a RESET take.
//   FSM: RUN->SERV (interrupt/BRK take), RUN->WAIT (WAI), RUN->STOP (STP),
//        SERV->RUN (vec_done), WAIT->RUN (wake), STOP->RUN (reset only).
// STRUCTURE
//   Shared package int_pkg: state encoding (RUN, SERV, WAIT, STOP), vector constants,
//     opcode constants (BRK, WAI, STP), source-select enum (RES, NMI, IRQ, BRK).
//   Sub-module edge_sync: NMI_SYNC-stage synchronizer plus rising-edge pulse.
//   The top holds the pending bits, the priority encoder, the FSM and the output registers.
// TESTING
//   Reset, then sync=1 with DB=8'hA9 -> force_brk=1. Next cycle: vec=FC, B=0, no_we=1.
//     After vec_done: no_we=0, state RUN.
//   nmi 0->1 with irq=1, I=0, then sync after 3 clocks -> vec=FA. At the next sync irq is
//     still high and I=0 -> vec=FE, B=0.
//   DB=8'h00 at sync, irq=0 -> force_brk=0; next cycle vec=FE, B=1.
//   irq=1, I=1 at sync with DB=8'hAD -> force_brk=0, no state change.
//     Then DB=OP_WAI -> halt=1. Raising irq later -> halt=0 next cycle, no service (I=1).
//   DB=OP_STP -> halt=1. nmi edges and irq=1 for 20 clocks -> halt stays 1.
//     reset pulse -> halt=0, vec=FC.
//   NMI edge in the same cycle as an NMI take -> nmi_pend remains 1 and a second NMI is
//     taken at the next sync. Assert reset during SERV -> all outputs at reset values
//     immediately (asynchronous).

Source files
------------

// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt/halt sequencer.
package int_seq_pkg;

  localparam int unsigned DATA_W = 8;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SERV = 2'd1,
    ST_WAIT = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  // Source selected at an opcode-fetch take
  typedef enum logic [1:0] {
    SRC_RES = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } src_e;

  localparam logic [DATA_W-1:0] VEC_NMI_DEF = 8'hFA;
  localparam logic [DATA_W-1:0] VEC_RES_DEF = 8'hFC;
  localparam logic [DATA_W-1:0] VEC_IRQ_DEF = 8'hFE;
  localparam logic [DATA_W-1:0] OP_BRK      = 8'h00;
  localparam logic [DATA_W-1:0] OP_WAI_DEF  = 8'hCB;
  localparam logic [DATA_W-1:0] OP_STP_DEF  = 8'hDB;

  // Fixed priority RESET > NMI > IRQ; BRK when no interrupt is pending
  function automatic src_e pick_src(input logic res, input logic nmi, input logic irq_en);
    if (res)         return SRC_RES;
    else if (nmi)    return SRC_NMI;
    else if (irq_en) return SRC_IRQ;
    else             return SRC_BRK;
  endfunction

endpackage

// File: rtl/int_seq_if.sv
// Core-side bus between the ctl FSM (master) and the interrupt sequencer (slave).
//   I, sync, rdy, DB, vec_done : ctl -> sequencer
//   force_brk, vec, B, no_we, halt : sequencer -> ctl
interface int_seq_if;
  import int_seq_pkg::*;

  logic              I;
  logic              sync;
  logic              rdy;
  logic [DATA_W-1:0] DB;
  logic              vec_done;
  logic              force_brk;
  logic [DATA_W-1:0] vec;
  logic              B;
  logic              no_we;
  logic              halt;

  modport master (
    output I, sync, rdy, DB, vec_done,
    input  force_brk, vec, B, no_we, halt
  );

  modport slave (
    input  I, sync, rdy, DB, vec_done,
    output force_brk, vec, B, no_we, halt
  );

endinterface

// File: rtl/int_seq_edge_sync.sv
// NMI pin synchronizer (STAGES flops, 0 = direct) followed by a rising-edge detector.
//   clk, reset : clock, async active-high reset
//   din        : asynchronous input pin
//   rise_c     : one-cycle pulse on a 0->1 transition of the synchronized input
module int_seq_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic sync_c;
  logic hist;

  generate
    if (STAGES == 0) begin : g_direct
      assign sync_c = din;
    end else begin : g_sync
      logic [STAGES-1:0] sr;

      // Synchronizer shift chain
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sr <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < int'(STAGES); i++) sr[i] <= sr[i-1];
        end
      end

      assign sync_c = sr[STAGES-1];
    end
  endgenerate

  // Edge history; cleared by reset so a pin held high through reset gives one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= 1'b0;
    else       hist <= sync_c;
  end

  assign rise_c = sync_c & ~hist;

endmodule

// File: rtl/int_seq.sv
// Interrupt and halt sequencer: arbitrates RESET/NMI/IRQ/BRK at opcode fetch, supplies the
// vector low byte and stacked B flag, blocks writes during reset, and handles WAI/STP.
//   clk, reset : clock, async active-high reset
//   nmi        : NMI pin (rising-edge, asynchronous)
//   irq        : IRQ pin (level, sampled at take)
//   bus        : slave side of int_seq_if (I, sync, rdy, DB, vec_done in;
//                force_brk (comb), vec, B, no_we, halt (registered) out)
module int_seq
  import int_seq_pkg::*;
#(
  parameter int unsigned       NMI_SYNC = 2,
  parameter logic [DATA_W-1:0] VEC_NMI  = VEC_NMI_DEF,
  parameter logic [DATA_W-1:0] VEC_RES  = VEC_RES_DEF,
  parameter logic [DATA_W-1:0] VEC_IRQ  = VEC_IRQ_DEF,
  parameter logic [DATA_W-1:0] OP_WAI   = OP_WAI_DEF,
  parameter logic [DATA_W-1:0] OP_STP   = OP_STP_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     nmi,
  input  logic     irq,
  int_seq_if.slave bus
);

  state_e            state, state_d;
  logic              res_pend, res_pend_d;
  logic              nmi_pend, nmi_pend_d;
  logic [DATA_W-1:0] vec_q, vec_d;
  logic              b_q, b_d;
  logic              no_we_q, no_we_d;
  logic              halt_q, halt_d;

  logic nmi_rise_c;
  logic take_c;
  logic irq_en_c;
  logic intr_c;
  logic serv_take_c;
  src_e src_c;

  int_seq_edge_sync #(.STAGES(NMI_SYNC)) u_nmi_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (nmi),
    .rise_c (nmi_rise_c)
  );

  // Arbitration at opcode fetch
  assign take_c      = bus.sync & bus.rdy & ~halt_q;
  assign irq_en_c    = irq & ~bus.I;
  assign intr_c      = res_pend | nmi_pend | irq_en_c;
  assign src_c       = pick_src(res_pend, nmi_pend, irq_en_c);
  assign serv_take_c = take_c & (intr_c | (bus.DB == OP_BRK));

  assign bus.force_brk = take_c & intr_c;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      res_pend <= 1'b1;
      nmi_pend <= 1'b0;
      vec_q    <= VEC_RES;
      b_q      <= 1'b0;
      no_we_q  <= 1'b1;
      halt_q   <= 1'b0;
    end else begin
      state    <= state_d;
      res_pend <= res_pend_d;
      nmi_pend <= nmi_pend_d;
      vec_q    <= vec_d;
      b_q      <= b_d;
      no_we_q  <= no_we_d;
      halt_q   <= halt_d;
    end
  end

  // Next-state logic; rdy=0 freezes every transition
  always_comb begin
    state_d = state;
    case (state)
      ST_RUN: begin
        if (take_c) begin
          if (serv_take_c)            state_d = ST_SERV;
          else if (bus.DB == OP_WAI)  state_d = ST_WAIT;
          else if (bus.DB == OP_STP)  state_d = ST_STOP;
        end
      end
      ST_SERV: if (bus.rdy && bus.vec_done)        state_d = ST_RUN;
      // Wake ignores I; a masked irq just resumes at the next opcode
      ST_WAIT: if (bus.rdy && (nmi_pend || irq))   state_d = ST_RUN;
      ST_STOP: state_d = ST_STOP;
    endcase
  end

  // Output / pending-bit next values
  always_comb begin
    res_pend_d = res_pend;
    nmi_pend_d = nmi_pend | nmi_rise_c;
    vec_d      = vec_q;
    b_d        = b_q;
    no_we_d    = no_we_q;

    if (state == ST_RUN && serv_take_c) begin
      case (src_c)
        SRC_RES: begin
          vec_d      = VEC_RES;
          b_d        = 1'b0;
          no_we_d    = 1'b1;
          res_pend_d = 1'b0;
        end
        SRC_NMI: begin
          vec_d      = VEC_NMI;
          b_d        = 1'b0;
          no_we_d    = 1'b0;
          // A fresh edge in the same cycle keeps NMI pending
          nmi_pend_d = nmi_rise_c;
        end
        SRC_IRQ: begin
          vec_d   = VEC_IRQ;
          b_d     = 1'b0;
          no_we_d = 1'b0;
        end
        SRC_BRK: begin
          vec_d   = VEC_IRQ;
          b_d     = 1'b1;
          no_we_d = 1'b0;
        end
      endcase
    end

    if (state == ST_SERV && bus.rdy && bus.vec_done) no_we_d = 1'b0;

    halt_d = (state_d == ST_WAIT) || (state_d == ST_STOP);
  end

  assign bus.vec   = vec_q;
  assign bus.B     = b_q;
  assign bus.no_we = no_we_q;
  assign bus.halt  = halt_q;

endmodule

// File: tb/tb_int_seq.sv
// Self-checking bench for int_seq: directed scenarios then randomized traffic, all checked
// against a cycle-level behavioural model of the sequencer rules.
module tb_int_seq;

  localparam int unsigned NS = 2;

  logic clk;
  logic reset;
  logic nmi;
  logic irq;

  int_seq_if bus();

  int_seq #(.NMI_SYNC(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .nmi   (nmi),
    .irq   (irq),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit       m_res, m_nmi, m_serv, m_wait, m_stop, m_b, m_nowe;
  bit [7:0] m_vec;
  bit       line [0:NS+1];   // line[j] = nmi as sampled j edges before the coming edge

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_res  = 1'b1;
    m_nmi  = 1'b0;
    m_serv = 1'b0;
    m_wait = 1'b0;
    m_stop = 1'b0;
    m_vec  = 8'hFC;
    m_b    = 1'b0;
    m_nowe = 1'b1;
    for (int j = 0; j <= NS + 1; j++) line[j] = 1'b0;
  endtask

  task automatic check_outs(input string ctx);
    chk({ctx, "_vec"},   bus.vec,          m_vec);
    chk({ctx, "_B"},     8'(bus.B),        8'(m_b));
    chk({ctx, "_no_we"}, 8'(bus.no_we),    8'(m_nowe));
    chk({ctx, "_halt"},  8'(bus.halt),     8'(m_wait | m_stop));
  endtask

  // One clock: check force_brk against the rules, advance the model, check registered outputs
  task automatic step();
    bit rise, take, irq_en, halted;
    #1;
    line[0] = nmi;
    rise    = line[NS] & ~line[NS+1];
    halted  = m_wait | m_stop;
    take    = bus.sync & bus.rdy & ~halted;
    irq_en  = irq & ~bus.I;
    chk("force_brk", 8'(bus.force_brk), 8'(take & (m_res | m_nmi | irq_en)));

    if (!m_serv && !halted && take) begin
      if (m_res) begin
        m_vec = 8'hFC; m_b = 1'b0; m_nowe = 1'b1; m_res = 1'b0; m_serv = 1'b1;
      end else if (m_nmi) begin
        m_vec = 8'hFA; m_b = 1'b0; m_nowe = 1'b0; m_nmi = 1'b0; m_serv = 1'b1;
      end else if (irq_en) begin
        m_vec = 8'hFE; m_b = 1'b0; m_nowe = 1'b0; m_serv = 1'b1;
      end else if (bus.DB == 8'h00) begin
        m_vec = 8'hFE; m_b = 1'b1; m_nowe = 1'b0; m_serv = 1'b1;
      end else if (bus.DB == 8'hCB) begin
        m_wait = 1'b1;
      end else if (bus.DB == 8'hDB) begin
        m_stop = 1'b1;
      end
    end else if (m_serv && bus.rdy && bus.vec_done) begin
      m_serv = 1'b0;
      m_nowe = 1'b0;
    end else if (m_wait && bus.rdy && (m_nmi || irq)) begin
      m_wait = 1'b0;
    end
    m_nmi = m_nmi | rise;
    for (int j = NS + 1; j >= 1; j--) line[j] = line[j-1];

    @(posedge clk);
    #1;
    check_outs("step");
  endtask

  // Asynchronous reset: outputs must change before any clock edge
  task automatic do_reset();
    reset        = 1'b1;
    bus.sync     = 1'b0;
    bus.vec_done = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulse_done();
    bus.vec_done = 1'b1;
    step();
    bus.vec_done = 1'b0;
  endtask

  int unsigned r;

  initial begin
    reset = 1'b1; nmi = 1'b0; irq = 1'b0;
    bus.I = 1'b1; bus.sync = 1'b0; bus.rdy = 1'b1; bus.DB = 8'hEA; bus.vec_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec",   bus.vec,        8'hFC);
    chk("rst_B",     8'(bus.B),      8'd0);
    chk("rst_no_we", 8'(bus.no_we),  8'd1);
    chk("rst_halt",  8'(bus.halt),   8'd0);
    reset = 1'b0;

    // Reset take on an ordinary opcode
    bus.sync = 1'b1; bus.DB = 8'hA9;
    #1 chk("t1_force", 8'(bus.force_brk), 8'd1);
    step();
    bus.sync = 1'b0;
    chk("t1_vec",   bus.vec,       8'hFC);
    chk("t1_no_we", 8'(bus.no_we), 8'd1);
    pulse_done();
    chk("t1_no_we_done", 8'(bus.no_we), 8'd0);

    // NMI beats a pending IRQ; IRQ serviced at the following fetch
    nmi = 1'b1; irq = 1'b1; bus.I = 1'b0; bus.DB = 8'hEA;
    repeat (3) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("t2_nmi_vec", bus.vec, 8'hFA);
    pulse_done();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("t2_irq_vec", bus.vec,   8'hFE);
    chk("t2_irq_B",   8'(bus.B), 8'd0);
    pulse_done();

    // Software BRK
    irq = 1'b0; bus.DB = 8'h00; bus.sync = 1'b1;
    #1 chk("t3_force", 8'(bus.force_brk), 8'd0);
    step();
    bus.sync = 1'b0;
    chk("t3_vec", bus.vec,   8'hFE);
    chk("t3_B",   8'(bus.B), 8'd1);
    pulse_done();

    // Masked IRQ, then WAI woken by masked IRQ without service
    irq = 1'b1; bus.I = 1'b1; bus.DB = 8'hAD; bus.sync = 1'b1;
    #1 chk("t4_force", 8'(bus.force_brk), 8'd0);
    step();
    irq = 1'b0; bus.DB = 8'hCB;
    step();
    bus.sync = 1'b0;
    chk("t4_halt", 8'(bus.halt), 8'd1);
    repeat (3) step();
    irq = 1'b1;
    step();
    chk("t4_wake", 8'(bus.halt), 8'd0);
    bus.sync = 1'b1; bus.DB = 8'hAD;
    step();
    bus.sync = 1'b0;
    chk("t4_no_serv_B", 8'(bus.B), 8'd1);

    // STP ignores nmi and irq; only reset exits
    irq = 1'b0; bus.DB = 8'hDB; bus.sync = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      nmi = i[1]; irq = 1'b1; bus.sync = i[0];
      step();
    end
    bus.sync = 1'b0;
    chk("t5_halt", 8'(bus.halt), 8'd1);
    nmi = 1'b0; irq = 1'b0;
    do_reset();
    chk("t5_halt_rst", 8'(bus.halt), 8'd0);
    chk("t5_vec_rst",  bus.vec,       8'hFC);
    bus.sync = 1'b1; bus.DB = 8'hEA;
    step();
    bus.sync = 1'b0;
    pulse_done();

    // NMI edge coincides with an NMI take: second NMI still pending
    bus.I = 1'b1;
    nmi = 1'b1; step();
    nmi = 1'b0; step();
    nmi = 1'b1; step();
    step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("t6_nmi1", bus.vec, 8'hFA);
    pulse_done();
    irq = 1'b1; bus.I = 1'b0; bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("t6_nmi2", bus.vec, 8'hFA);
    pulse_done();
    irq = 1'b0; bus.I = 1'b1;

    // Reset during SERV
    bus.DB = 8'h00; bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (m_stop && $urandom_range(0, 7) == 0) begin
        do_reset();
        continue;
      end
      bus.rdy      = ($urandom_range(0, 3) != 0);
      bus.sync     = !m_serv && ($urandom_range(0, 1) == 1);
      bus.vec_done = m_serv && ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      bus.DB = 8'h00;
      else if (r == 1) bus.DB = 8'hCB;
      else if (r == 2) bus.DB = 8'hDB;
      else             bus.DB = 8'($urandom);
      irq   = ($urandom_range(0, 5) == 0);
      bus.I = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 6) == 0) nmi = ~nmi;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
